// File: rtl/cache_stream_demux.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with one holding slot per channel.
// Supports unicast and broadcast; illegal selects are dropped and flagged in sel_err.
module cache_stream_demux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_OUT),
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [SEL_WIDTH-1:0]           in_sel,
    input  logic                           in_bcast,
    output logic [NUM_OUT-1:0]             out_valid,
    input  logic [NUM_OUT-1:0]             out_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0]  out_data,
    output logic                           sel_err,
    input  logic                           err_clr,
    output logic [CNT_WIDTH-1:0]           beat_cnt
);

    logic [NUM_OUT-1:0]                 valid_q;
    logic [NUM_OUT-1:0][DATA_WIDTH-1:0] data_q;
    logic [NUM_OUT-1:0]                 slot_free;
    logic [NUM_OUT-1:0]                 load;
    logic                               sel_legal;
    logic                               sel_free;
    logic                               accept;
    logic                               drop;

    // Ready/accept decode; in_sel is matched per channel so an illegal select never indexes out of range.
    always_comb begin
        slot_free = ~valid_q | out_ready;
        sel_legal = (32'(in_sel) < NUM_OUT);
        sel_free  = 1'b0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (SEL_WIDTH'(i) == in_sel) begin
                sel_free = slot_free[i];
            end
        end

        if (rst) begin
            in_ready = 1'b0;
        end else if (in_bcast) begin
            in_ready = &slot_free;
        end else if (!sel_legal) begin
            in_ready = 1'b1;
        end else begin
            in_ready = sel_free;
        end

        accept = in_valid & in_ready;
        drop   = accept & ~in_bcast & ~sel_legal;
        load   = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            load[i] = accept & (in_bcast | (sel_legal & (SEL_WIDTH'(i) == in_sel)));
        end
    end

    // Empty channels present zero data even though data_q keeps its last value.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = valid_q[i] ? data_q[i] : '0;
        end
    end

    assign out_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            data_q   <= '0;
            sel_err  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (load[i]) begin
                    valid_q[i] <= 1'b1;
                    data_q[i]  <= in_data;
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (accept) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
            // A new illegal beat outranks a same-cycle clear.
            if (drop) begin
                sel_err <= 1'b1;
            end else if (err_clr) begin
                sel_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cache_stream_demux.sv
// Bench for cache_stream_demux (NUM_OUT=3, CNT_WIDTH=4): directed scenarios plus random
// traffic, checked against a per-channel queue model of the demux.
module tb_cache_stream_demux;

    localparam int unsigned DW = 32;
    localparam int unsigned NO = 3;
    localparam int unsigned SW = 2;
    localparam int unsigned CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [SW-1:0]    in_sel;
    logic             in_bcast;
    logic [NO-1:0]    out_valid;
    logic [NO-1:0]    out_ready;
    logic [NO*DW-1:0] out_data;
    logic             sel_err;
    logic             err_clr;
    logic [CW-1:0]    beat_cnt;

    cache_stream_demux #(
        .DATA_WIDTH(DW), .NUM_OUT(NO), .SEL_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err), .err_clr(err_clr), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each channel is a queue of at most one pending beat.
    logic [DW-1:0] mq [NO][$];
    int            m_cnt;
    bit            m_err;
    bit            last_acc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        bit all_free = 1'b1;
        for (int i = 0; i < int'(NO); i++)
            if (mq[i].size() != 0 && !out_ready[i]) all_free = 1'b0;
        if (rst) return 1'b0;
        if (in_bcast) return all_free;
        if (int'(in_sel) >= int'(NO)) return 1'b1;
        return (mq[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < int'(NO); i++) begin
            check($sformatf("out_valid%0d", i), 128'(out_valid[i]), 128'(mq[i].size() != 0));
            check($sformatf("out_data%0d", i), 128'(out_data[i*DW +: DW]),
                  (mq[i].size() != 0) ? 128'(mq[i][0]) : 128'(0));
        end
        check("sel_err", 128'(sel_err), 128'(m_err));
        check("beat_cnt", 128'(beat_cnt), 128'(m_cnt % 16));
    endtask

    task automatic drive(input bit v, input int sel, input bit bc, input logic [DW-1:0] d,
                         input logic [NO-1:0] ordy, input bit clr);
        in_valid  = v;
        in_sel    = SW'(sel);
        in_bcast  = bc;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
    endtask

    // One clock: predict in_ready, advance the model over the edge, then compare state.
    task automatic step();
        bit rdy;
        bit acc;
        #1;
        rdy = model_ready();
        check("in_ready", 128'(in_ready), 128'(rdy));
        @(posedge clk);
        acc = in_valid && rdy;
        for (int i = 0; i < int'(NO); i++)
            if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
        if (acc) begin
            m_cnt++;
            if (in_bcast) begin
                for (int i = 0; i < int'(NO); i++) mq[i].push_back(in_data);
            end else if (int'(in_sel) < int'(NO)) begin
                mq[in_sel].push_back(in_data);
            end
        end
        if (acc && !in_bcast && int'(in_sel) >= int'(NO)) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        last_acc = acc;
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, '0, '0, 0);
        m_cnt = 0;
        m_err = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Unicast sweep with all consumers ready.
        for (int k = 0; k < int'(NO); k++) begin
            drive(1, k, 0, DW'(32'h11 * (k + 1)), '1, 0);
            step();
        end
        drive(0, 0, 0, '0, '1, 0);
        step();
        check("sweep_cnt", 128'(beat_cnt), 128'(3));

        // Reset mid-stream while channel 2 holds a stalled beat.
        drive(1, 2, 0, 32'hDEADBEEF, 3'b011, 0);
        step();
        drive(0, 0, 0, '0, 3'b011, 0);
        step();
        check("held_data", 128'(out_data[2*DW +: DW]), 128'(32'hDEADBEEF));
        rst = 1'b1;
        #1;
        for (int i = 0; i < int'(NO); i++) mq[i].delete();
        m_cnt = 0;
        m_err = 1'b0;
        check("rst_in_ready2", 128'(in_ready), 128'(0));
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, 1, 0, 32'h0000_0077, 3'b000, 0);
        step();

        // Backpressure on channel 1: second beat waits, then drain and refill together.
        drive(0, 0, 0, '0, '1, 0);
        step();
        drive(1, 1, 0, 32'hA, 3'b101, 0);
        step();
        drive(1, 1, 0, 32'hB, 3'b101, 0);
        step();
        check("bp_stall", 128'(last_acc), 128'(0));
        step();
        drive(1, 1, 0, 32'hB, 3'b111, 0);
        step();
        check("bp_refill", 128'(out_data[DW +: DW]), 128'(32'hB));
        drive(1, 0, 0, 32'hC, 3'b101, 0);
        step();
        check("bp_ch0_accept", 128'(last_acc), 128'(1));

        // Broadcast blocked by a full, stalled channel 2.
        drive(1, 2, 0, 32'h1234, 3'b011, 0);
        step();
        drive(1, 0, 1, 32'h5A5A5A5A, 3'b011, 0);
        step();
        check("bc_stall", 128'(last_acc), 128'(0));
        drive(1, 0, 1, 32'h5A5A5A5A, 3'b111, 0);
        step();
        check("bc_valid", 128'(out_valid), 128'(3'b111));

        // Illegal select: dropped, flagged; set beats a same-cycle clear.
        drive(1, 3, 0, 32'hBAD, 3'b111, 0);
        step();
        check("ill_err", 128'(sel_err), 128'(1));
        drive(1, 3, 0, 32'hBAD2, 3'b111, 1);
        step();
        check("ill_set_wins", 128'(sel_err), 128'(1));
        drive(0, 0, 0, '0, 3'b111, 1);
        step();
        check("ill_clr", 128'(sel_err), 128'(0));

        // Continuous drain/refill on channel 0; counter wraps along the way.
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 0, DW'(32'h100 + k), 3'b111, 0);
            step();
            check("stream_acc", 128'(last_acc), 128'(1));
        end

        // Random traffic with a producer that holds its beat until accepted.
        last_acc = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = SW'($urandom_range(0, 3));
                in_bcast = ($urandom_range(0, 7) == 0);
                in_data  = $urandom;
            end
            out_ready = NO'($urandom);
            err_clr   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
